input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//  Front end between raw FPGA pins (hall/cab buttons, floor sensors, alerts) and the input register bank.
//  Per bit: 2-flop synchroniser, then a debounce filter.
//  Per group: drives held debounced values plus a 1-cycle write-enable pulse when any bit of the group changes.
//  Outputs connect 1:1 to the input register bank's value/_we inputs.
// PARAMETERS
//  N_FLOORS        8    width of button_up/down/select_floor and floor_sensor groups
//  DEBOUNCE_CYC    1000 consecutive stable synchronised cycles required to accept a button/sensor change (>=2)
//  ALERT_DEB_CYC   16   same, for overweight_alert and fire_alert (>=2; shorter for fast alarm response)
// PORTS
//  clk                     in   1         system clock
//  rst_n                   in   1         asynchronous reset, active low
//  raw_button_up           in   N_FLOORS  async hall-up buttons, 1 = pressed
//  raw_button_down         in   N_FLOORS  async hall-down buttons
//  raw_button_close        in   1         async cab door-close button
//  raw_button_open         in   1         async cab door-open button
//  raw_button_select_floor in   N_FLOORS  async cab floor-select buttons
//  raw_floor_sensor        in   N_FLOORS  async floor-position sensors
//  raw_overweight_alert    in   1         async load-cell alarm
//  raw_fire_alert          in   1         async fire alarm
//  button_up / _we         out  N_FLOORS/1 debounced value / change pulse
//  button_down / _we       out  N_FLOORS/1 likewise
//  button_close / _we      out  1/1       likewise
//  button_open / _we       out  1/1       likewise
//  button_select_floor/_we out  N_FLOORS/1 likewise
//  floor_sensor / _we      out  N_FLOORS/1 likewise
//  overweight_alert / _we  out  1/1       likewise
//  fire_alert / _we        out  1/1       likewise
// BEHAVIOUR
//  Reset (async, rst_n=0): all sync flops, debounced values, counters and every output = 0, FSMs -> STABLE.
//  Synchroniser: s1<=raw, s2<=s1. No logic between s1 and s2.
//  Per-bit FSM (N = DEBOUNCE_CYC, or ALERT_DEB_CYC for alert bits):
//   STABLE : s2==deb -> stay, cnt=0. s2!=deb -> PENDING, cnt<=1.
//   PENDING: s2==deb -> STABLE, cnt<=0 (glitch rejected, no pulse).
//            s2!=deb and cnt==N-1 -> deb<=s2, chg<=1, STABLE, cnt<=0.
//            else cnt<=cnt+1.
//   Counter width $clog2(N+1). Counter never wraps; it saturates via the exit at N-1.
//  chg is a 1-cycle registered pulse, asserted in the same cycle deb takes its new value.
//  Latency: a clean raw edge is visible on the value output, with _we=1, N+2 cycles after it is first sampled by s1.
//  Group _we = OR of the group's chg bits. The value output and _we are valid in the same cycle; value is held otherwise.
//  Several bits of one group accepted on the same cycle -> exactly one _we pulse, showing all new bits.
//  Bits accepted on consecutive cycles -> _we on consecutive cycles, no merging or loss.
//  Raw input held 1 through reset release -> accepted N+2 cycles after release, with a _we pulse.
//   This initialises downstream registers; no separate power-on sequence.
//  Reset asserted mid-count: count discarded, deb=0. Raw toggling every <N cycles: output never changes.
//  Groups are independent. No handshake back-pressure: the consumer must sample on every _we.
// STRUCTURE
//  Shared package elevator_pkg: N_FLOORS, DEBOUNCE_CYC / ALERT_DEB_CYC defaults, STABLE/PENDING state encoding.
//  Sub-module debounce_cell #(N): clk, rst_n, raw -> deb, chg (sync + FSM + counter, one bit).
//  Top level: generate loops instantiating debounce_cell per bit, plus per-group OR/pulse logic.
// TESTING (bench with DEBOUNCE_CYC=8, ALERT_DEB_CYC=4)
//  raw_button_up=8'h04 held -> button_up=8'h04 with button_up_we=1 for exactly 1 cycle, 10 cycles after first s1 sample.
//  raw_button_close high for 5 cycles then low -> no button_close_we pulse, button_close stays 0.
//  raw_floor_sensor 8'h00->8'h81 on the same edge -> single floor_sensor_we pulse, value 8'h81.
//  raw_fire_alert=1 -> fire_alert_we at +6 cycles; raw_button_open=1 on the same edge -> button_open_we at +10 cycles.
//  raw_button_select_floor=8'h10 held through rst_n release -> _we pulse at +10 cycles after release.
//   rst_n pulsed low mid-count -> outputs 0 immediately; count restarts after release.
//  Bit 0 accepted, bit 1 one cycle later -> button_down_we on two consecutive cycles (8'h01 then 8'h03).

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator constants and the per-bit debounce state encoding.
// Imported by the input conditioner and its debounce cells.
package elevator_pkg;

    localparam int N_FLOORS_DEF      = 8;
    localparam int DEBOUNCE_CYC_DEF  = 1000;
    localparam int ALERT_DEB_CYC_DEF = 16;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: two-flop synchroniser followed by a debounce FSM.
// A change is accepted after N consecutive stable synchronised cycles.
module debounce_cell
    import elevator_pkg::*;
#(
    parameter int N = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb,
    output logic chg
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          s1_q;
    logic          s2_q;
    deb_state_e    state_q;
    deb_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_q;
    logic          deb_d;
    logic          chg_q;
    logic          chg_d;

    // Next-state logic; the count exits at N-1, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        chg_d   = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != deb_q) begin
                    state_d = PENDING;
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = ZERO;
                end
            end
            PENDING: begin
                if (s2_q == deb_q) begin
                    state_d = STABLE;
                    cnt_d   = ZERO;
                end else if (cnt_q == LAST) begin
                    deb_d   = s2_q;
                    chg_d   = 1'b1;
                    state_d = STABLE;
                    cnt_d   = ZERO;
                end else begin
                    cnt_d   = cnt_q + ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= ZERO;
            deb_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            chg_q   <= chg_d;
        end
    end

    assign deb = deb_q;
    assign chg = chg_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw elevator pins into debounced values plus per-group
// write-enable pulses that feed the input register bank directly.
module input_conditioner
    import elevator_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int ALERT_DEB_CYC = ALERT_DEB_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] raw_button_up,
    input  logic [N_FLOORS-1:0] raw_button_down,
    input  logic                raw_button_close,
    input  logic                raw_button_open,
    input  logic [N_FLOORS-1:0] raw_button_select_floor,
    input  logic [N_FLOORS-1:0] raw_floor_sensor,
    input  logic                raw_overweight_alert,
    input  logic                raw_fire_alert,
    output logic [N_FLOORS-1:0] button_up,
    output logic                button_up_we,
    output logic [N_FLOORS-1:0] button_down,
    output logic                button_down_we,
    output logic                button_close,
    output logic                button_close_we,
    output logic                button_open,
    output logic                button_open_we,
    output logic [N_FLOORS-1:0] button_select_floor,
    output logic                button_select_floor_we,
    output logic [N_FLOORS-1:0] floor_sensor,
    output logic                floor_sensor_we,
    output logic                overweight_alert,
    output logic                overweight_alert_we,
    output logic                fire_alert,
    output logic                fire_alert_we
);

    // All bits are flattened into one vector; the two alerts sit at the top.
    localparam int NF      = N_FLOORS;
    localparam int W       = 4 * NF + 4;
    localparam int UP_LO   = 0;
    localparam int DN_LO   = NF;
    localparam int CLOSE_I = 2 * NF;
    localparam int OPEN_I  = 2 * NF + 1;
    localparam int SEL_LO  = 2 * NF + 2;
    localparam int FLR_LO  = 3 * NF + 2;
    localparam int OW_I    = 4 * NF + 2;
    localparam int FIRE_I  = 4 * NF + 3;

    logic [W-1:0] raw_s;
    logic [W-1:0] deb_s;
    logic [W-1:0] chg_s;
    logic [W-1:0] val_q;
    logic [W-1:0] val_d;
    logic [7:0]   we_q;
    logic [7:0]   we_d;

    assign raw_s = {raw_fire_alert, raw_overweight_alert, raw_floor_sensor,
                    raw_button_select_floor, raw_button_open, raw_button_close,
                    raw_button_down, raw_button_up};

    for (genvar i = 0; i < W; i++) begin : g_cell
        localparam int CYC = (i >= OW_I) ? ALERT_DEB_CYC : DEBOUNCE_CYC;
        debounce_cell #(.N(CYC)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_s[i]),
            .deb   (deb_s[i]),
            .chg   (chg_s[i])
        );
    end

    // Group pulse is the OR of its bits' change flags, so simultaneous
    // acceptances inside one group collapse into a single write.
    always_comb begin
        val_d    = deb_s;
        we_d     = 8'h00;
        we_d[0]  = |chg_s[UP_LO +: NF];
        we_d[1]  = |chg_s[DN_LO +: NF];
        we_d[2]  = chg_s[CLOSE_I];
        we_d[3]  = chg_s[OPEN_I];
        we_d[4]  = |chg_s[SEL_LO +: NF];
        we_d[5]  = |chg_s[FLR_LO +: NF];
        we_d[6]  = chg_s[OW_I];
        we_d[7]  = chg_s[FIRE_I];
    end

    // Output registers: value and write-enable change in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= {W{1'b0}};
            we_q  <= 8'h00;
        end else begin
            val_q <= val_d;
            we_q  <= we_d;
        end
    end

    assign button_up              = val_q[UP_LO +: NF];
    assign button_down            = val_q[DN_LO +: NF];
    assign button_close           = val_q[CLOSE_I];
    assign button_open            = val_q[OPEN_I];
    assign button_select_floor    = val_q[SEL_LO +: NF];
    assign floor_sensor           = val_q[FLR_LO +: NF];
    assign overweight_alert       = val_q[OW_I];
    assign fire_alert             = val_q[FIRE_I];
    assign button_up_we           = we_q[0];
    assign button_down_we         = we_q[1];
    assign button_close_we        = we_q[2];
    assign button_open_we         = we_q[3];
    assign button_select_floor_we = we_q[4];
    assign floor_sensor_we        = we_q[5];
    assign overweight_alert_we    = we_q[6];
    assign fire_alert_we          = we_q[7];

endmodule
